// File: rtl/int16_dot_accum_pkg.sv
// Shared definitions for the int16 dot-product accumulator.
//   DATA_W    - width of products and sums
//   SUM_MAX   - most positive signed 16-bit sum
//   SUM_MIN   - most negative signed 16-bit sum
//   sat_add16 - 16-bit add that wraps, or clamps to the signed range when sat is set
package int16_dot_accum_pkg;

    localparam int unsigned DATA_W = 16;
    localparam logic [DATA_W-1:0] SUM_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SUM_MIN = 16'h8000;

    function automatic logic [DATA_W-1:0] sat_add16(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic              sat);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // Sign-extended sum: the top two bits differ only on signed overflow.
        if (sat && (s[DATA_W] != s[DATA_W-1])) begin
            return s[DATA_W] ? SUM_MIN : SUM_MAX;
        end
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/int16_dot_fifo.sv
// Synchronous first-word-fall-through FIFO holding completed sums.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clr_i         - synchronous clear back to the reset state
//   push_i        - write wdata_i (refused when full unless a pop happens the same cycle)
//   pop_i         - remove the head entry (ignored when empty)
//   rdata_o       - head entry; holds the last popped entry while empty
//   valid_o       - FIFO non-empty
//   level_o       - number of entries held
//   drop_o        - push refused this cycle because the FIFO was full
module int16_dot_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 23
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       valid_o,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic                       drop_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q, level_d;
    logic [Width-1:0] last_q;
    logic             full, empty, push_ok, pop_ok;

    assign full    = (level_q == LvlW'(Depth));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop_i & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push_i & (~full | pop_ok);
    assign drop_o  = push_i & ~push_ok;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LvlW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            level_q <= level_d;
        end
    end

    assign valid_o = ~empty;
    assign rdata_o = empty ? last_q : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/int16_dot_accum.sv
// Accumulates a never-stalling stream of 16-bit products into per-vector sums and queues each
// completed sum for a ready/valid reader.
//   clk, rst_n         - clock, asynchronous active-low reset
//   clr                - synchronous clear of accumulator, beat count, FIFO and sticky flags
//   in_valid/in_product/in_last - product beat, last beat of the vector
//   out_valid/out_ready/out_sum/out_len - FWFT head of completed sums and its beat count
//   fifo_level         - entries held
//   ovf_err            - sticky: a completed sum was dropped on a full FIFO
//   len_err            - sticky: a vector reached MAX_LEN beats without in_last
module int16_dot_accum
    import int16_dot_accum_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned SAT     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_product,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_sum,
    output logic [$clog2(MAX_LEN+1)-1:0] out_len,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         ovf_err,
    output logic                         len_err
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);
    localparam logic [LenW-1:0] LastCnt = LenW'(MAX_LEN - 1);

    logic [DATA_W-1:0]      acc_q, acc_next;
    logic [LenW-1:0]        cnt_q, cnt_next;
    logic                   ovf_q, len_q;
    logic                   at_max, close, push, pop, drop;
    logic [DATA_W+LenW-1:0] rdata;

    assign acc_next = sat_add16(acc_q, in_product, SAT != 0);
    assign cnt_next = cnt_q + LenW'(1);
    assign at_max   = (cnt_q == LastCnt);
    assign close    = in_valid & (in_last | at_max);
    // clr wins over both the closing push and the reader's pop.
    assign push     = close & ~clr;
    assign pop      = out_ready & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            len_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            len_q <= 1'b0;
        end else begin
            if (in_valid) begin
                acc_q <= close ? '0 : acc_next;
                cnt_q <= close ? '0 : cnt_next;
            end
            if (in_valid && !in_last && at_max) begin
                len_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    int16_dot_fifo #(
        .Depth (DEPTH),
        .Width (DATA_W + LenW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .push_i  (push),
        .wdata_i ({acc_next, cnt_next}),
        .pop_i   (pop),
        .rdata_o (rdata),
        .valid_o (out_valid),
        .level_o (fifo_level),
        .drop_o  (drop)
    );

    assign out_sum = rdata[DATA_W+LenW-1:LenW];
    assign out_len = rdata[LenW-1:0];
    assign ovf_err = ovf_q;
    assign len_err = len_q;

endmodule

// File: tb/tb_int16_dot_accum.sv
module tb_int16_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, out_ready;
    logic [15:0] in_product;

    // u_wrap: SAT=0, u_sat: SAT=1, u_short: MAX_LEN=4; all share the same stimulus.
    logic        w_valid, s_valid, m_valid;
    logic [15:0] w_sum, s_sum, m_sum;
    logic [6:0]  w_len, s_len;
    logic [2:0]  m_len;
    logic [2:0]  w_lvl, s_lvl, m_lvl;
    logic        w_ovf, s_ovf, m_ovf, w_lerr, s_lerr, m_lerr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int16_dot_accum #(.DEPTH(4), .MAX_LEN(64), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_product(in_product),
        .in_last(in_last), .out_valid(w_valid), .out_ready(out_ready), .out_sum(w_sum),
        .out_len(w_len), .fifo_level(w_lvl), .ovf_err(w_ovf), .len_err(w_lerr)
    );

    int16_dot_accum #(.DEPTH(4), .MAX_LEN(64), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_product(in_product),
        .in_last(in_last), .out_valid(s_valid), .out_ready(out_ready), .out_sum(s_sum),
        .out_len(s_len), .fifo_level(s_lvl), .ovf_err(s_ovf), .len_err(s_lerr)
    );

    int16_dot_accum #(.DEPTH(4), .MAX_LEN(4), .SAT(0)) u_short (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_product(in_product),
        .in_last(in_last), .out_valid(m_valid), .out_ready(out_ready), .out_sum(m_sum),
        .out_len(m_len), .fifo_level(m_lvl), .ovf_err(m_ovf), .len_err(m_lerr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p, input logic last);
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] sum;
        logic [6:0]  len;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_acc;
    logic [6:0]  m_cnt;
    int          drops, vlen, b;
    logic        vld;

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_product = '0;

        // Reset
        repeat (4) tick();
        check("rst_valid", w_valid, 0);
        check("rst_sum", w_sum, 0);
        check("rst_len", w_len, 0);
        check("rst_level", w_lvl, 0);
        check("rst_flags", {w_ovf, w_lerr}, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_valid", w_valid, 0);

        // Basic vector: 6 + 77 + 20000 + 1 = 20084
        beat(16'd6, 1'b0);
        beat(16'd77, 1'b0);
        beat(16'd20000, 1'b0);
        check("basic_not_yet", w_valid, 0);
        beat(16'd1, 1'b1);
        check("basic_valid", w_valid, 1);
        check("basic_sum", w_sum, 20084);
        check("basic_len", w_len, 4);
        check("basic_level", w_lvl, 1);
        check("basic_sat_sum", s_sum, 20084);
        check("basic_short_sum", m_sum, 20084);
        check("basic_short_lerr", m_lerr, 0);
        pop_one();
        check("pop_empty", w_valid, 0);
        check("pop_hold_sum", w_sum, 20084);
        check("pop_hold_len", w_len, 4);
        pop_one();
        check("empty_ready_noop", w_sum, 20084);

        // Wrap vs saturate
        beat(16'h7FFF, 1'b0);
        beat(16'h0002, 1'b1);
        check("wrap_pos", w_sum, 16'h8001);
        check("sat_pos", s_sum, 16'h7FFF);
        check("sat_pos_len", s_len, 2);
        pop_one();
        beat(16'h8000, 1'b0);
        beat(16'hFFFF, 1'b1);
        check("wrap_neg", w_sum, 16'h7FFF);
        check("sat_neg", s_sum, 16'h8000);
        pop_one();

        // Backpressure: five single-beat vectors into a 4-deep FIFO
        pulse_clr();
        for (int i = 1; i <= 5; i++) beat(16'(i), 1'b1);
        check("bp_level", w_lvl, 4);
        check("bp_ovf", w_ovf, 1);
        for (int i = 1; i <= 4; i++) begin
            check("bp_drain", w_sum, i);
            check("bp_drain_len", w_len, 1);
            pop_one();
        end
        check("bp_empty", w_lvl, 0);

        // Full with simultaneous push and pop
        pulse_clr();
        for (int i = 10; i <= 13; i++) beat(16'(i), 1'b1);
        check("full_level", w_lvl, 4);
        check("full_no_ovf", w_ovf, 0);
        out_ready = 1'b1;
        beat(16'd14, 1'b1);
        out_ready = 1'b0;
        check("pp_level", w_lvl, 4);
        check("pp_no_ovf", w_ovf, 0);
        for (int i = 11; i <= 14; i++) begin
            check("pp_drain", w_sum, i);
            pop_one();
        end

        // MAX_LEN=4 auto-terminate
        pulse_clr();
        for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
        check("max_valid", m_valid, 1);
        check("max_sum", m_sum, 4);
        check("max_len", m_len, 4);
        check("max_lerr", m_lerr, 1);
        check("max_wide_lerr", w_lerr, 0);
        beat(16'd1, 1'b0);
        check("max_level_after5", m_lvl, 1);
        beat(16'd2, 1'b1);
        check("max_level_after_last", m_lvl, 2);
        check("max_wide_sum", w_sum, 7);
        check("max_wide_len", w_len, 6);
        pop_one();
        check("max_second_sum", m_sum, 3);
        check("max_second_len", m_len, 2);
        check("max_lerr_sticky", m_lerr, 1);

        // clr beats a closing beat and a pop in the same cycle
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        beat(16'd7, 1'b1);
        beat(16'd8, 1'b1);
        beat(16'd5, 1'b0);
        check("clr_pre_level", w_lvl, 2);
        clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_product = 16'd3; out_ready = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        check("clr_level", w_lvl, 0);
        check("clr_valid", w_valid, 0);
        check("clr_sum", w_sum, 0);
        check("clr_len", w_len, 0);
        check("clr_lerr", m_lerr, 0);
        check("clr_ovf", w_ovf, 0);
        beat(16'd9, 1'b1);
        check("clr_acc_sum", w_sum, 9);
        check("clr_acc_len", w_len, 1);

        // Random vectors against a golden model with random out_ready
        pulse_clr();
        q.delete();
        m_acc = '0; m_cnt = '0; drops = 0;
        for (int v = 0; v < 1000; v++) begin
            vlen = $urandom_range(1, 8);
            b = 0;
            while (b < vlen) begin
                vld        = ($urandom_range(0, 3) != 0);
                in_valid   = vld;
                in_product = 16'($urandom);
                in_last    = (b == vlen - 1);
                out_ready  = 1'($urandom_range(0, 1));
                check("rnd_valid", w_valid, q.size() != 0);
                if (q.size() != 0 && out_ready) begin
                    check("rnd_sum", w_sum, q[0].sum);
                    check("rnd_len", w_len, q[0].len);
                    q.delete(0);
                end
                if (vld) begin
                    m_acc = m_acc + in_product;
                    m_cnt = m_cnt + 7'd1;
                    b++;
                    if (in_last) begin
                        if (q.size() < 4) q.push_back('{m_acc, m_cnt});
                        else drops++;
                        m_acc = '0;
                        m_cnt = '0;
                    end
                end
                tick();
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6 && q.size() != 0; i++) begin
            check("rnd_drain_sum", w_sum, q[0].sum);
            check("rnd_drain_len", w_len, q[0].len);
            q.delete(0);
            tick();
        end
        out_ready = 1'b0;
        check("rnd_drained", w_lvl, 0);
        check("rnd_ovf", w_ovf, drops != 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
